// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and size constants for the data-memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    function automatic logic size_legal(input logic [2:0] bytes);
        return (bytes == SIZE_BYTE) || (bytes == SIZE_HALF) || (bytes == SIZE_WORD);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane select for loads and lane merge for stores
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  bytes_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] ram_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wr_word_o,
    output logic [31:0] rd_data_o,
    output logic        misalign_o
);

    logic [3:0]  lane_en;
    logic [31:0] ram_shifted;
    logic [31:0] wdata_shifted;

    assign ram_shifted   = ram_word_i >> {offset_i, 3'b000};
    assign wdata_shifted = wdata_i << {offset_i, 3'b000};

    always_comb begin
        lane_en    = 4'b0000;
        rd_data_o  = 32'h0;
        misalign_o = 1'b0;
        case (bytes_i)
            SIZE_BYTE: begin
                lane_en   = 4'b0001 << offset_i;
                rd_data_o = {24'h0, ram_shifted[7:0]};
            end
            SIZE_HALF: begin
                lane_en    = 4'b0011 << offset_i;
                rd_data_o  = {16'h0, ram_shifted[15:0]};
                misalign_o = offset_i[0];
            end
            SIZE_WORD: begin
                lane_en    = 4'b1111;
                rd_data_o  = ram_word_i;
                misalign_o = (offset_i != 2'd0);
            end
            default: ;
        endcase
    end

    // Lanes outside the access keep the current RAM contents.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_word_o[8*i +: 8] = lane_en[i] ? wdata_shifted[8*i +: 8] : ram_word_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle load/store responder with wait states and local error checks
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int WORDS       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_bytes,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int          AW            = $clog2(WORDS);
    localparam logic [31:0] WORDS_U       = 32'(WORDS);
    localparam logic [3:0]  WAIT_CNT_INIT = 4'(WAIT_CYCLES);

    mem_state_t  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        write_q;
    logic [2:0]  bytes_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic [31:0] mem [WORDS];

    logic        accept;
    logic        enter_resp;
    logic        op_write;
    logic [2:0]  op_bytes;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [31:0] ram_word;
    logic [31:0] wr_word;
    logic [31:0] ld_data;
    logic        misalign;
    logic        op_err;
    logic        commit;

    assign accept = (state_q == IDLE) && req_valid && req_ready_q;

    // With zero wait states RESP is entered on the acceptance edge, so the
    // operation is taken straight from the request inputs in that case.
    assign op_write = (state_q == IDLE) ? req_write : write_q;
    assign op_bytes = (state_q == IDLE) ? req_bytes : bytes_q;
    assign op_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    assign ram_word = mem[op_addr[AW+1:2]];

    mem_lane_align u_lane_align (
        .bytes_i    (op_bytes),
        .offset_i   (op_addr[1:0]),
        .ram_word_i (ram_word),
        .wdata_i    (op_wdata),
        .wr_word_o  (wr_word),
        .rd_data_o  (ld_data),
        .misalign_o (misalign)
    );

    assign op_err = !size_legal(op_bytes) || misalign || ({2'b00, op_addr[31:2]} >= WORDS_U);

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign commit     = enter_resp && op_write && !op_err;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wait_cnt_d = WAIT_CNT_INIT;
                    state_d    = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == RESP) && (state_q != RESP)) begin
            resp_error_d = op_err;
            resp_rdata_d = (op_err || op_write) ? 32'h0 : ld_data;
        end else if (state_d != RESP) begin
            resp_error_d = 1'b0;
            resp_rdata_d = 32'h0;
        end

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 4'd0;
            req_ready_q  <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
            write_q      <= 1'b0;
            bytes_q      <= 3'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            req_ready_q  <= req_ready_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            if (accept) begin
                write_q <= req_write;
                bytes_q <= req_bytes;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[op_addr[AW+1:2]] <= wr_word;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int WORDS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
    logic [2:0]  req_bytes;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        z_rst, z_req_valid, z_req_ready, z_req_write, z_resp_valid, z_resp_ready, z_resp_error;
    logic [2:0]  z_req_bytes;
    logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

    data_mem_responder #(.WORDS(WORDS), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bytes(req_bytes), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    data_mem_responder #(.WORDS(WORDS), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(z_rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_bytes(z_req_bytes), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_error(z_resp_error)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [2:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    function automatic vec_t mkv(input string n, input logic w, input logic [2:0] b,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] rd, input logic er);
        vec_t v;
        v.name = n; v.w = w; v.b = b; v.a = a; v.d = d; v.exp_rd = rd; v.exp_er = er;
        return v;
    endfunction

    // Byte-addressed reference memory.
    logic [7:0] mm [WORDS*4];

    function automatic void model(input logic w, input logic [2:0] b, input logic [31:0] a,
                                  input logic [31:0] d, output logic [31:0] rd, output logic er);
        int nb;
        nb = int'(b);
        rd = 32'h0;
        er = !(nb == 1 || nb == 2 || nb == 4);
        if (!er) er = ((a % nb) != 0) || ((a / 4) >= WORDS);
        if (!er) begin
            for (int i = 0; i < nb; i++) begin
                if (w) mm[a + i] = d[8*i +: 8];
                else   rd[8*i +: 8] = mm[a + i];
            end
        end
    endfunction

    // Called #1 after a rising edge with the responder idle.
    task automatic do_req(input logic w, input logic [2:0] b, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat, output logic rdy_after);
        int n;
        req_write = w; req_bytes = b; req_addr = a; req_wdata = d;
        req_valid = 1'b1; resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_bytes = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = resp_rdata; er = resp_error;
        @(posedge clk); #1;
        rdy_after = req_ready;
    endtask

    vec_t        vecs[$];
    logic [31:0] rd, exp_rd;
    logic        er, exp_er, rdy;
    int          lat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; z_rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_bytes = 3'd4; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_bytes = 3'd4; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b0;

        // Reset release
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_req_ready", 32'(req_ready), 32'd0);
            chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1; z_rst = 1'b1;
        #1 chk("ready_before_first_edge", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 32'(req_ready), 32'd1);
        chk("valid_after_release", 32'(resp_valid), 32'd0);

        // Directed vectors, WAIT_CYCLES = 2
        vecs.push_back(mkv("st_w_0",      1, 3'd4, 32'h00,  32'h11223344, 32'h0,        0));
        vecs.push_back(mkv("st_w_20",     1, 3'd4, 32'h20,  32'h00000000, 32'h0,        0));
        vecs.push_back(mkv("st_w_10",     1, 3'd4, 32'h10,  32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mkv("ld_w_10",     0, 3'd4, 32'h10,  32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(mkv("st_b_11",     1, 3'd1, 32'h11,  32'h00000055, 32'h0,        0));
        vecs.push_back(mkv("ld_merge",    0, 3'd4, 32'h10,  32'h0,        32'hDEAD55EF, 0));
        vecs.push_back(mkv("ld_h_12",     0, 3'd2, 32'h12,  32'h0,        32'h0000DEAD, 0));
        vecs.push_back(mkv("ld_b_13",     0, 3'd1, 32'h13,  32'h0,        32'h000000DE, 0));
        vecs.push_back(mkv("st_h_13_err", 1, 3'd2, 32'h13,  32'hBEEF,     32'h0,        1));
        vecs.push_back(mkv("ld_range",    0, 3'd4, 32'(WORDS*4), 32'h0,   32'h0,        1));
        vecs.push_back(mkv("st_size3",    1, 3'd3, 32'h00,  32'hFFFFFFFF, 32'h0,        1));
        vecs.push_back(mkv("ld_10_kept",  0, 3'd4, 32'h10,  32'h0,        32'hDEAD55EF, 0));
        vecs.push_back(mkv("ld_0_kept",   0, 3'd4, 32'h00,  32'h0,        32'h11223344, 0));
        vecs.push_back(mkv("ld_h_11_err", 0, 3'd2, 32'h11,  32'h0,        32'h0,        1));
        vecs.push_back(mkv("st_h_12",     1, 3'd2, 32'h12,  32'hABCD1234, 32'h0,        0));
        vecs.push_back(mkv("ld_w_half",   0, 3'd4, 32'h10,  32'h0,        32'h123455EF, 0));
        vecs.push_back(mkv("ld_b_10",     0, 3'd1, 32'h10,  32'h0,        32'h000000EF, 0));
        vecs.push_back(mkv("st_w_last",   1, 3'd4, 32'(WORDS*4-4), 32'hA5A5C3C3, 32'h0, 0));
        vecs.push_back(mkv("ld_b_last",   0, 3'd1, 32'(WORDS*4-1), 32'h0, 32'h000000A5, 0));
        vecs.push_back(mkv("ld_size0",    0, 3'd0, 32'h00,  32'h0,        32'h0,        1));
        vecs.push_back(mkv("st_w_02_err", 1, 3'd4, 32'h02,  32'h0,        32'h0,        1));
        vecs.push_back(mkv("ld_0_after",  0, 3'd4, 32'h00,  32'h0,        32'h11223344, 0));

        foreach (vecs[k]) begin
            do_req(vecs[k].w, vecs[k].b, vecs[k].a, vecs[k].d, rd, er, lat, rdy);
            chk({vecs[k].name, "_rdata"}, rd, vecs[k].exp_rd);
            chk({vecs[k].name, "_error"}, 32'(er), 32'(vecs[k].exp_er));
            chk({vecs[k].name, "_latency"}, 32'(lat), 32'd3);
            chk({vecs[k].name, "_ready_after"}, 32'(rdy), 32'd1);
        end

        // Reset mid-WAIT aborts the store
        req_write = 1'b1; req_bytes = 3'd4; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("midwait_in_wait", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("midwait_req_ready", 32'(req_ready), 32'd0);
        chk("midwait_resp_valid", 32'(resp_valid), 32'd0);
        chk("midwait_resp_rdata", resp_rdata, 32'h0);
        chk("midwait_resp_error", 32'(resp_error), 32'd0);
        @(posedge clk); #1;
        chk("midwait_valid_held", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midwait_ready_back", 32'(req_ready), 32'd1);
        do_req(1'b0, 3'd4, 32'h20, 32'h0, rd, er, lat, rdy);
        chk("midwait_store_aborted", rd, 32'h0);
        chk("midwait_load_error", 32'(er), 32'd0);

        // Zero wait states with response backpressure
        z_req_write = 1'b1; z_req_bytes = 3'd4; z_req_addr = 32'h40; z_req_wdata = 32'hCAFEF00D;
        z_req_valid = 1'b1;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        chk("z_store_latency", 32'(z_resp_valid), 32'd1);
        chk("z_store_error", 32'(z_resp_error), 32'd0);
        z_resp_ready = 1'b1;
        @(posedge clk); #1;
        z_resp_ready = 1'b0;
        chk("z_store_ready_after", 32'(z_req_ready), 32'd1);

        z_req_write = 1'b0; z_req_bytes = 3'd4; z_req_addr = 32'h40;
        z_req_valid = 1'b1;
        @(posedge clk); #1;
        z_req_write = 1'b1; z_req_addr = 32'h40; z_req_wdata = 32'h0BADBAD0;
        chk("z_load_latency", 32'(z_resp_valid), 32'd1);
        chk("z_load_rdata", z_resp_rdata, 32'hCAFEF00D);
        chk("z_load_ready_low", 32'(z_req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("z_bp_valid", 32'(z_resp_valid), 32'd1);
            chk("z_bp_rdata", z_resp_rdata, 32'hCAFEF00D);
            chk("z_bp_ready_low", 32'(z_req_ready), 32'd0);
        end
        z_req_valid = 1'b0;
        z_resp_ready = 1'b1;
        @(posedge clk); #1;
        z_resp_ready = 1'b0;
        chk("z_hs_valid_low", 32'(z_resp_valid), 32'd0);
        chk("z_hs_ready_high", 32'(z_req_ready), 32'd1);
        z_req_write = 1'b0; z_req_addr = 32'h40; z_req_valid = 1'b1; z_resp_ready = 1'b1;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        chk("z_ignored_store", z_resp_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        z_resp_ready = 1'b0;

        // Randomized traffic against the byte-level model
        for (int wi = 0; wi < WORDS; wi++) begin
            logic [31:0] d;
            d = $urandom;
            model(1'b1, 3'd4, 32'(wi * 4), d, exp_rd, exp_er);
            do_req(1'b1, 3'd4, 32'(wi * 4), d, rd, er, lat, rdy);
            if (er !== 1'b0) chk("init_error", 32'(er), 32'd0);
        end
        for (int n = 0; n < 200; n++) begin
            logic        w;
            logic [2:0]  b;
            logic [31:0] a, d;
            w = 1'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0: b = 3'd1;
                    1: b = 3'd2;
                    default: b = 3'd4;
                endcase
            end else begin
                b = 3'($urandom_range(0, 7));
            end
            a = (32'($urandom_range(0, WORDS + 1)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            model(w, b, a, d, exp_rd, exp_er);
            do_req(w, b, a, d, rd, er, lat, rdy);
            chk("rand_rdata", rd, exp_rd);
            chk("rand_error", 32'(er), 32'(exp_er));
            chk("rand_latency", 32'(lat), 32'd3);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder answering load/store requests from the CPU's load/store path over a valid/ready request channel and a valid/ready response channel. It holds a word-organised little-endian RAM, inserts a programmable number of wait states, and performs byte/half/word lane selection and merging. Range and alignment checks are done locally and reported through an error response. Read data is returned right-justified and zero-filled. The CPU keeps responsibility for sign extension.

## Interface
- `WORDS`, default 1024: RAM depth in 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, default 2: wait states between request acceptance and response; range 0..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_bytes`  in  3  access size; legal values 1, 2, 4.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified; unused upper bits ignored.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  initiator accepts the response.
- `resp_rdata`  out  32  load data, right-justified, zero-filled above the access size; 0 for stores and errors.
- `resp_error`  out  1  request was rejected; no write occurred.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid && req_ready`, capture `write`, `bytes`, `addr`, `wdata` and load `wait_cnt` = `WAIT_CYCLES`.
  - Go to WAIT, or straight to RESP when `WAIT_CYCLES` = 0.
- **WAIT**
  - `req_ready` = 0.
  - `wait_cnt` decrements each cycle.
  - When `wait_cnt` = 1, the next state is RESP.
- **Entering RESP**, on the same edge:
  - Evaluate the error condition and register `resp_rdata` and `resp_error`.
  - Commit the store lanes if there is no error.
- **RESP**
  - `resp_valid` = 1; `resp_rdata` and `resp_error` are held stable until `resp_valid && resp_ready`.
  - On that handshake, go to IDLE.
- **Error condition:** any of the following.
  - `bytes` ∉ {1, 2, 4}.
  - `addr % bytes` ≠ 0.
  - `addr[31:2]` ≥ `WORDS`.
- **Lane rules** (little-endian, word index `addr[31:2]`, byte offset `addr[1:0]`):
  - Byte access uses lane `offset`.
  - Half access uses lanes `offset` and `offset+1`, with `offset` ∈ {0, 2}.
  - Word access uses all four lanes.
  - Stores update only the addressed lanes; the other lanes keep their value.
- Loads return RAM contents as of the RESP-entry edge.
- The RAM array is never reset; its contents are undefined until written.

## Timing
- Reset values, with `rst` low:
  - State = IDLE, `wait_cnt` = 0.
  - `req_ready` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_error` = 0.
- `req_ready` is registered and rises on the first rising edge after `rst` deasserts.
- `req_ready` is also registered low on the edge that accepts a request.
- Latency: acceptance edge to `resp_valid` high is `WAIT_CYCLES` + 1 cycles.
- After the response handshake, `req_ready` = 1 on the next cycle.
- Minimum request spacing is `WAIT_CYCLES` + 2 cycles.
- Request inputs are ignored outside IDLE.
- `resp_ready` is ignored outside RESP.
- A `resp_ready` held high before RESP completes the handshake on the first RESP cycle.
- Reset asserted mid-operation:
  - Return to IDLE immediately with all outputs at their reset values.
  - A store is aborted if reset arrives before the RESP-entry edge.
  - A store that has already committed remains in RAM.
- `req_valid` held high with no handshake has no effect; requests are never lost once accepted.

## Structure
- Package `mem_pkg`:
  - `mem_state_t` enum {IDLE, WAIT, RESP}.
  - Size constants `SIZE_BYTE` = 1, `SIZE_HALF` = 2, `SIZE_WORD` = 4.
- Sub-module `mem_lane_align`, combinational:
  - Inputs: `bytes`, `offset`, RAM word, `wdata`.
  - Outputs: the merged store word, the right-justified load data and a misalignment flag.
- Top level: FSM, wait counter, capture registers, RAM array and error evaluation.

## Test plan
- **Reset release:** hold `rst` low for 3 cycles, then release.
  - `req_ready` = 0 during reset and 1 one cycle after release.
  - `resp_valid` = 0 throughout.
- **Word store then load:** with `WAIT_CYCLES` = 2, store `addr` = 0x10, `bytes` = 4, `wdata` = 0xDEADBEEF, then load the same address.
  - `resp_valid` rises 3 cycles after each acceptance.
  - The load returns `resp_rdata` = 0xDEADBEEF, `resp_error` = 0.
- **Lane merge:** after the word store, store `addr` = 0x11, `bytes` = 1, `wdata` = 0x55, then load word 0x10.
  - Load returns 0xDEAD55EF.
  - A half load at 0x12 returns 0x0000DEAD.
- **Errors:** issue a half store at 0x13, a word load at `WORDS`*4, and `bytes` = 3 at 0x0.
  - Each returns `resp_error` = 1 and `resp_rdata` = 0.
  - A following load of the targeted words shows their contents unchanged.
- **Backpressure and zero wait:** with `WAIT_CYCLES` = 0, hold `resp_ready` = 0 for 5 cycles.
  - `resp_valid` rises 1 cycle after acceptance.
  - Response data stays stable while `resp_ready` = 0.
  - `req_ready` stays 0 until the cycle after the handshake.
- **Reset mid-WAIT:** accept a word store 0x12345678 at 0x20, then pulse `rst` low during WAIT.
  - Outputs go to their reset values.
  - A load of 0x20 after reset does not return 0x12345678, given 0x20 was pre-written with 0.
